// File: rtl/core_test_monitor.sv
// Test-run monitor: counts RUN cycles/instructions, ends the run on ECALL, timeout or stuck PC.
// Termination captures status/result on the deciding edge, done is high the next cycle; no backpressure.
module core_test_monitor #(
    parameter int XLEN        = 32,
    parameter int AWIDTH      = 32,
    parameter int CNT_W       = 32,
    parameter int TO_W        = 16,
    parameter int HANG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inst_valid,
    input  logic [XLEN-1:0]   inst,
    input  logic [AWIDTH-1:0] pc,
    input  logic [XLEN-1:0]   result_in,
    input  logic [TO_W-1:0]   timeout_limit,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [XLEN-1:0]   result,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count
);
    localparam int HW    = $clog2(HANG_CYCLES + 1);
    localparam int CMP_W = (CNT_W > TO_W) ? CNT_W : TO_W;
    localparam logic [XLEN-1:0] ECALL_INST = XLEN'(32'h0000_0073);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_ECALL   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_HANG    = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        status_q, status_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  inst_cnt_q, inst_cnt_d;
    logic [HW-1:0]     hang_cnt_q, hang_cnt_d;
    logic [AWIDTH-1:0] pc_q, pc_d;

    logic is_ecall;
    logic is_timeout;
    logic pc_same;
    logic is_hang;

    assign is_ecall   = inst_valid && (inst == ECALL_INST);
    // Compare at the wider of the two widths so neither side is truncated.
    assign is_timeout = (timeout_limit != '0) &&
                        (CMP_W'(cycle_cnt_q) == (CMP_W'(timeout_limit) - CMP_W'(1)));
    assign pc_same    = (pc == pc_q);
    assign is_hang    = pc_same && (hang_cnt_q == HW'(HANG_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        result_d    = result_q;
        cycle_cnt_d = cycle_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        hang_cnt_d  = hang_cnt_q;
        pc_d        = pc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    status_d    = ST_NONE;
                    result_d    = '0;
                    cycle_cnt_d = '0;
                    inst_cnt_d  = '0;
                    hang_cnt_d  = '0;
                    pc_d        = pc;
                end
            end
            RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                if (inst_valid && (inst_cnt_q != '1)) begin
                    inst_cnt_d = inst_cnt_q + CNT_W'(1);
                end
                if (pc_same) begin
                    hang_cnt_d = hang_cnt_q + HW'(1);
                end else begin
                    hang_cnt_d = '0;
                    pc_d       = pc;
                end
                if (is_ecall) begin
                    state_d  = DONE;
                    status_d = ST_ECALL;
                    result_d = result_in;
                end else if (is_timeout) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                    result_d = result_in;
                end else if (is_hang) begin
                    state_d  = DONE;
                    status_d = ST_HANG;
                    result_d = result_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            status_q    <= ST_NONE;
            result_q    <= '0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            hang_cnt_q  <= '0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            result_q    <= result_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            hang_cnt_q  <= hang_cnt_d;
            pc_q        <= pc_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign status      = status_q;
    assign result      = result_q;
    assign cycle_count = cycle_cnt_q;
    assign inst_count  = inst_cnt_q;

endmodule

// File: tb/tb_core_test_monitor.sv
// Scoreboard bench for core_test_monitor: stimulus queues expectations, a negedge monitor checks them.
module tb_core_test_monitor;
    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [1:0]  K_NOW  = 2'd0;
    localparam logic [1:0]  K_DONE = 2'd1;
    localparam logic [1:0]  K_SAT  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        busy;
        logic        done;
        logic [1:0]  status;
        logic [31:0] result;
        logic [31:0] cyc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, inst_valid;
    logic [31:0] inst, pc, result_in;
    logic [15:0] timeout_limit;
    logic        busy, done;
    logic [1:0]  status;
    logic [31:0] result, cycle_count, inst_count;
    logic        busy4, done4;
    logic [1:0]  status4;
    logic [31:0] result4;
    logic [3:0]  cycle_count4, inst_count4;

    exp_t  exp_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  done_prev;

    always #5 clk = ~clk;

    core_test_monitor dut (
        .clk(clk), .rst(rst), .start(start), .inst_valid(inst_valid), .inst(inst),
        .pc(pc), .result_in(result_in), .timeout_limit(timeout_limit),
        .busy(busy), .done(done), .status(status), .result(result),
        .cycle_count(cycle_count), .inst_count(inst_count)
    );

    core_test_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .inst_valid(inst_valid), .inst(inst),
        .pc(pc), .result_in(result_in), .timeout_limit(timeout_limit),
        .busy(busy4), .done(done4), .status(status4), .result(result4),
        .cycle_count(cycle_count4), .inst_count(inst_count4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input string nm, input logic b, input logic d,
                        input logic [1:0] st, input logic [31:0] r, input logic [31:0] c,
                        input logic [31:0] n);
        exp_t e;
        e.kind = k; e.busy = b; e.done = d; e.status = st;
        e.result = r; e.cyc = c; e.inst = n;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=0x%0h want=0x%0h", nm, fld, act, want);
        end
    endtask

    task automatic compare_all(input string nm, input exp_t e);
        chk(nm, "busy", 32'(busy), 32'(e.busy));
        chk(nm, "done", 32'(done), 32'(e.done));
        chk(nm, "status", 32'(status), 32'(e.status));
        chk(nm, "result", result, e.result);
        chk(nm, "cycle_count", cycle_count, e.cyc);
        chk(nm, "inst_count", inst_count, e.inst);
    endtask

    // Give the monitor a bounded number of cycles to consume everything queued so far.
    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain %s: pending=%0d want=0", nm_q[0], exp_q.size());
            exp_q.delete();
            nm_q.delete();
        end
    endtask

    initial begin
        exp_t  e;
        string nm;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].kind != K_DONE) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                if (e.kind == K_SAT) begin
                    chk(nm, "cycle_count4", 32'(cycle_count4), e.cyc);
                    chk(nm, "inst_count4", 32'(inst_count4), e.inst);
                end else begin
                    compare_all(nm, e);
                end
            end
            if (exp_q.size() != 0 && done && !done_prev) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                compare_all(nm, e);
            end
            done_prev = done;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; inst_valid = 1'b0; inst = '0;
        pc = '0; result_in = '0; timeout_limit = '0;
        tick();
        tick();
        push(K_NOW, "reset", 0, 0, 2'b00, 0, 0, 0);
        drain(4);
        rst = 1'b0;

        // ECALL after ten ADDIs on incrementing pc
        pc = '0; start = 1'b1; tick(); start = 1'b0;
        push(K_NOW, "ecall_start", 1, 0, 2'b00, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            inst_valid = 1'b1; inst = ADDI; pc = 32'(4 * i);
            tick();
        end
        push(K_DONE, "ecall", 0, 1, 2'b01, 32'd1, 32'd11, 32'd11);
        inst = ECALL; pc = 32'd44; result_in = 32'd1;
        tick();
        inst_valid = 1'b0; inst = '0;
        drain(10);

        // Restart from DONE, then timeout at 100 with instructions every other cycle
        timeout_limit = 16'd100; result_in = 32'hDEAD_0002;
        start = 1'b1; tick(); start = 1'b0;
        push(K_NOW, "restart", 1, 0, 2'b00, 0, 0, 0);
        push(K_DONE, "timeout", 0, 1, 2'b10, 32'hDEAD_0002, 32'd100, 32'd50);
        for (int i = 0; i < 105; i++) begin
            inst_valid = i[0]; inst = ADDI; pc = 32'h1000 + 32'(4 * i);
            tick();
        end
        inst_valid = 1'b0;
        drain(4);

        // PC stuck at 0x80 from the first RUN cycle
        timeout_limit = '0; pc = 32'h80; result_in = 32'h0000_0BAD;
        start = 1'b1; tick(); start = 1'b0;
        push(K_DONE, "hang", 0, 1, 2'b11, 32'h0000_0BAD, 32'd64, 32'd0);
        repeat (70) tick();
        drain(4);

        // PC moves at sample 63: hang counter restarts, fires 64 samples later
        result_in = 32'h0BAD_0003;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 130; i++) begin
            pc = (i >= 63) ? 32'h84 : 32'h80;
            tick();
            if (i == 64) begin
                push(K_NOW, "no_hang_at_63", 1, 0, 2'b00, 0, 32'd64, 32'd0);
                push(K_DONE, "hang_late", 0, 1, 2'b11, 32'h0BAD_0003, 32'd127, 32'd0);
            end
        end
        drain(4);

        // ECALL on the same edge as the timeout
        timeout_limit = 16'd5; result_in = 32'd7;
        start = 1'b1; tick(); start = 1'b0;
        push(K_DONE, "ecall_vs_timeout", 0, 1, 2'b01, 32'd7, 32'd5, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pc = 32'h200 + 32'(4 * i);
            inst_valid = (i == 5);
            inst = (i == 5) ? ECALL : ADDI;
            tick();
        end
        inst_valid = 1'b0;
        drain(4);

        // start while busy is ignored; reset mid-run clears everything
        timeout_limit = '0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            pc = 32'h300 + 32'(4 * i); inst_valid = 1'b1; inst = ADDI;
            start = (i == 3);
            tick();
            if (i == 5) push(K_NOW, "start_ignored", 1, 0, 2'b00, 0, 32'd5, 32'd5);
        end
        start = 1'b0; rst = 1'b1;
        tick();
        push(K_NOW, "midrun_reset", 0, 0, 2'b00, 0, 0, 0);
        rst = 1'b0; inst_valid = 1'b0;
        drain(4);

        // Saturation on the 4-bit instance, wide instance keeps counting
        result_in = 32'd9;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            pc = 32'h400 + 32'(4 * i); inst_valid = 1'b1; inst = ADDI;
            tick();
            if (i == 20) begin
                push(K_SAT, "sat20", 0, 0, 2'b00, 0, 32'd15, 32'd15);
                push(K_NOW, "wide20", 1, 0, 2'b00, 0, 32'd20, 32'd20);
            end
            if (i == 25) push(K_SAT, "sat25", 0, 0, 2'b00, 0, 32'd15, 32'd15);
        end
        push(K_DONE, "sat_end", 0, 1, 2'b01, 32'd9, 32'd26, 32'd26);
        inst = ECALL; pc = 32'h500;
        tick();
        inst_valid = 1'b0; inst = '0;
        drain(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_test_monitor.md
CORE_TEST_MONITOR -- requirements
Module: core_test_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction and result width.
REQ-002 SHALL have parameter AWIDTH, default 32, meaning program-counter width.
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of the cycle and instruction counters.
REQ-004 SHALL have parameter TO_W, default 16, meaning width of the timeout limit.
REQ-005 SHALL have parameter HANG_CYCLES, default 64 (minimum 2), meaning the number of consecutive equal-PC samples that flags a hang.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: arms or re-arms a test run.
REQ-009 SHALL have port inst_valid, input, 1 bit: inst holds a decoded instruction this cycle.
REQ-010 SHALL have port inst, input, XLEN bits: the instruction currently in decode.
REQ-011 SHALL have port pc, input, AWIDTH bits: the core program counter.
REQ-012 SHALL have port result_in, input, XLEN bits: the test result register (x3/gp) value.
REQ-013 SHALL have port timeout_limit, input, TO_W bits: the run-cycle budget; 0 disables the timeout.
REQ-014 SHALL have port busy, output, 1 bit: high in RUN.
REQ-015 SHALL have port done, output, 1 bit: high in DONE.
REQ-016 SHALL have port status, output, 2 bits: 00 none, 01 ecall, 10 timeout, 11 hang.
REQ-017 SHALL have port result, output, XLEN bits: result_in captured at termination.
REQ-018 SHALL have port cycle_count, output, CNT_W bits: RUN cycles elapsed.
REQ-019 SHALL have port inst_count, output, CNT_W bits: valid instructions seen in RUN.

Function
REQ-020 SHALL implement states IDLE, RUN and DONE; the outputs busy and done are decoded directly from the state.
REQ-021 Transition IDLE->RUN SHALL occur on start=1; the same edge SHALL clear cycle_count, inst_count, result, status and the hang counter, and load pc_q with pc.
REQ-022 In RUN, start SHALL be ignored.
REQ-023 In RUN, cycle_count SHALL increment by 1 every cycle.
REQ-024 In RUN, inst_count SHALL increment by 1 on every cycle where inst_valid=1, including the terminating ECALL cycle.
REQ-025 cycle_count and inst_count SHALL saturate at all-ones and not wrap.
REQ-026 ECALL SHALL be detected when in RUN with inst_valid=1 and inst==32'h0000_0073 (zero-extended/compared on XLEN bits); on that edge the block SHALL go to DONE, set status=01 and capture result<=result_in, so done is high in the following cycle.
REQ-027 Timeout SHALL be detected when in RUN, timeout_limit!=0 and cycle_count==timeout_limit-1; on that edge the block SHALL go to DONE with status=10 and result<=result_in, leaving final cycle_count==timeout_limit.
REQ-028 Hang detection in RUN, every cycle: if pc==pc_q, hang_cnt increments; otherwise hang_cnt clears to 0 and pc_q<=pc.
REQ-029 A hang SHALL be detected when pc==pc_q and hang_cnt==HANG_CYCLES-1; on that edge the block SHALL go to DONE with status=11 and result<=result_in.
REQ-030 When several terminations occur in the same cycle, priority SHALL be ECALL > timeout > hang, and only one status SHALL be recorded.
REQ-031 In DONE, all outputs SHALL hold and the counters SHALL freeze; start=1 SHALL perform the REQ-021 clear and re-enter RUN on the same edge.
REQ-032 In IDLE and DONE, inst_valid, pc and result_in SHALL have no effect.
REQ-033 The block SHALL be fully synthesizable, with no delays or system tasks.

Reset
REQ-034 rst=1 SHALL, at the next clk edge and overriding start, force IDLE and zero busy, done, status, result, cycle_count, inst_count, hang_cnt and pc_q, including during RUN or DONE.
REQ-035 rst SHALL have no asynchronous effect.

Verification
REQ-036 Test ECALL: rst, then start, then 10 cycles with inst_valid=1 and ADDI instructions on incrementing pc, then ECALL with result_in=1. Required: done=1 on the next cycle, status=01, result=1, inst_count=11, cycle_count=11.
REQ-037 Test timeout: timeout_limit=100, with pc changing every cycle and no ECALL. Required: done rises after 100 RUN cycles, status=10, cycle_count=100.
REQ-038 Test hang: HANG_CYCLES=64, timeout_limit=0, with pc held at 0x80 from the first RUN cycle. Required: done rises after 64 RUN cycles, status=11. A further run where pc changes at sample 63 SHALL NOT flag a hang at that point.
REQ-039 Test simultaneous events: ECALL on the same cycle as timeout (limit=5, ECALL on the 5th RUN cycle). Required: status=01.
REQ-040 Test restart and mid-run reset: start in DONE clears the counters and sets busy=1 on the next cycle; rst=1 at RUN cycle 7 gives all outputs 0 on the next cycle; start while busy=1 leaves the counters uninterrupted.
REQ-041 Test saturation: CNT_W=4 with 20 RUN cycles (timeout disabled, pc changing). Required: cycle_count=15 holds.
